// File: rtl/sobel_stream_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sobel_stream_packer
// Description : Packs the 8-bit Sobel pixel stream into 32-bit AXI-Stream
//               beats (4 pixels per beat, first pixel in [7:0]) for a DMA
//               S2MM channel. The beat carrying the frame's last pixel is
//               marked with m_axis_tlast, and a partial final word gets a
//               reduced tkeep. o_frame_done pulses for one cycle after that
//               beat is accepted.
//               Optional macro SOBEL_BINARIZE_EN: each pixel is replaced by
//               8'hFF (pixel >= i_thresh) or 8'h00 before packing.
// Revision    : 1.0  initial release
// ============================================================================
module sobel_stream_packer #(
    parameter int PIX_PER_FRAME = 262144,
    parameter int CNT_W         = 20
) (
    input  logic        axi_clk,
    input  logic        axi_reset_n,
    input  logic        s_axis_tvalid,
    input  logic [7:0]  s_axis_tdata,
    output logic        s_axis_tready,
    output logic        m_axis_tvalid,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    input  logic [7:0]  i_thresh,
    output logic        o_frame_done
);

    localparam logic [CNT_W-1:0] c_last_pix = CNT_W'(PIX_PER_FRAME - 1);

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_done_nxt;
    logic              r_frame_done;

    logic [23:0]       r_pack;
    logic [1:0]        r_idx;
    logic [CNT_W-1:0]  r_cnt;

    logic              r_m_tvalid;
    logic [31:0]       r_m_tdata;
    logic [3:0]        r_m_tkeep;
    logic              r_m_tlast;

    logic [7:0]        w_pix;
    logic              w_last_pix;
    logic              w_word_end;
    logic              w_out_stall;
    logic              w_s_tready;
    logic              w_accept;
    logic              w_load;
    logic [31:0]       w_word;
    logic [3:0]        w_keep;

`ifdef SOBEL_BINARIZE_EN
    // Threshold the incoming pixel; i_thresh is taken on the accepting edge
    assign w_pix = (s_axis_tdata >= i_thresh) ? 8'hFF : 8'h00;
`else
    logic w_unused_thresh;
    assign w_pix           = s_axis_tdata;
    assign w_unused_thresh = ^i_thresh;
`endif

    // A word closes on lane 3 or on the frame's last pixel (short final word)
    assign w_last_pix  = (r_cnt == c_last_pix);
    assign w_word_end  = (r_idx == 2'd3) | w_last_pix;
    assign w_out_stall = r_m_tvalid & ~m_axis_tready;
    // Refuse only the byte that would need the output register while it is stuck
    assign w_s_tready  = (r_state == FILL) & ~(w_word_end & w_out_stall);
    assign w_accept    = s_axis_tvalid & w_s_tready;
    assign w_load      = w_accept & w_word_end;

    // Assemble the completed word from held bytes plus the incoming byte; unused lanes zero
    always_comb begin
        w_word = 32'h0;
        w_keep = 4'h0;
        case (r_idx)
            2'd0: begin
                w_word = {24'h0, w_pix};
                w_keep = 4'b0001;
            end
            2'd1: begin
                w_word = {16'h0, w_pix, r_pack[7:0]};
                w_keep = 4'b0011;
            end
            2'd2: begin
                w_word = {8'h0, w_pix, r_pack[15:0]};
                w_keep = 4'b0111;
            end
            default: begin
                w_word = {w_pix, r_pack[23:0]};
                w_keep = 4'b1111;
            end
        endcase
    end

    // Pack register, lane index and frame pixel counter
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_pack <= 24'h0;
            r_idx  <= 2'd0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_cnt <= w_last_pix ? '0 : (r_cnt + CNT_W'(1));
            if (w_load) begin
                r_pack <= 24'h0;
                r_idx  <= 2'd0;
            end else begin
                case (r_idx)
                    2'd0:    r_pack[7:0]   <= w_pix;
                    2'd1:    r_pack[15:8]  <= w_pix;
                    default: r_pack[23:16] <= w_pix;
                endcase
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    // Output register: load on word completion, release on handshake
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= 32'h0;
            r_m_tkeep  <= 4'h0;
            r_m_tlast  <= 1'b0;
        end else if (w_load) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= w_word;
            r_m_tkeep  <= w_keep;
            r_m_tlast  <= w_last_pix;
        end else if (m_axis_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    // State register and registered frame-done pulse
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_state      <= FILL;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_done_nxt;
        end
    end

    // Next state: DRAIN holds off input until the tlast beat is taken
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            FILL: begin
                if (w_load && w_last_pix) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (r_m_tvalid && m_axis_tready) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = FILL;
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    assign s_axis_tready = w_s_tready;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tkeep  = r_m_tkeep;
    assign m_axis_tlast  = r_m_tlast;
    assign o_frame_done  = r_frame_done;

endmodule
`default_nettype wire
